// File: rtl/acc_fwd_scheduler_if.sv
// acc_fwd_scheduler bus bundle: descriptor, chunk, datapath and output sides.
// master = environment (sources, datapath, sink); slave = scheduler.
interface acc_fwd_scheduler_if #(
  parameter int DATA_W = 1024,
  parameter int GRP_W  = 16
);
  logic              i_desc_valid;
  logic              o_desc_ready;
  logic [3:0]        i_desc_mode;
  logic [GRP_W-1:0]  i_desc_groups;
  logic              i_chunk_valid;
  logic              o_chunk_ready;
  logic [31:0]       i_chunk_sum;
  logic [DATA_W-1:0] i_chunk_data;
  logic              o_dp_en;
  logic              o_dp_valid_sum;
  logic [3:0]        o_dp_length_mode;
  logic [31:0]       o_dp_loc_sum;
  logic [DATA_W-1:0] o_dp_in_flat;
  logic              i_dp_valid_sum;
  logic              o_out_valid;
  logic              i_out_ready;
  logic              o_out_grp_last;
  logic              o_out_desc_last;
  logic              o_err;
  logic              o_idle;

  modport master (
    output i_desc_valid, i_desc_mode, i_desc_groups,
    output i_chunk_valid, i_chunk_sum, i_chunk_data,
    output i_dp_valid_sum, i_out_ready,
    input  o_desc_ready, o_chunk_ready,
    input  o_dp_en, o_dp_valid_sum, o_dp_length_mode,
    input  o_dp_loc_sum, o_dp_in_flat,
    input  o_out_valid, o_out_grp_last, o_out_desc_last,
    input  o_err, o_idle
  );

  modport slave (
    input  i_desc_valid, i_desc_mode, i_desc_groups,
    input  i_chunk_valid, i_chunk_sum, i_chunk_data,
    input  i_dp_valid_sum, i_out_ready,
    output o_desc_ready, o_chunk_ready,
    output o_dp_en, o_dp_valid_sum, o_dp_length_mode,
    output o_dp_loc_sum, o_dp_in_flat,
    output o_out_valid, o_out_grp_last, o_out_desc_last,
    output o_err, o_idle
  );
endinterface

// File: rtl/acc_fwd_scheduler.sv
// acc_fwd_scheduler: turns row descriptors into gap-free chunk groups
// for the accumulator datapath and tags its output beats.
module acc_fwd_scheduler #(
  parameter int DATA_W = 1024,
  parameter int DP_LAT = 12,
  parameter int GRP_W  = 16
) (
  input logic i_clk,
  input logic i_rst,
  acc_fwd_scheduler_if.slave bus
);

  localparam int IFW = $clog2(DP_LAT + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [3:0]               mode_q;
  logic [GRP_W-1:0]         grp_left_q;
  logic [3:0]               beat_cnt_q;
  logic [IFW-1:0]           inflight_q;
  logic [DP_LAT-1:0][1:0]   tag_q;
  logic                     err_q;

  logic                     run;
  logic                     desc_acc;
  logic                     bad_mode;
  logic                     grp_nz;
  logic [3:0]               beats_m1;
  logic                     beat_last;
  logic                     out_block;
  logic                     starve;
  logic                     dp_en;
  logic                     issue;
  logic                     desc_end;
  logic                     out_xfer;
  logic [DATA_W-1:0]        flat;

  assign run      = (state_q == RUN);
  assign bad_mode = (bus.i_desc_mode[3:1] == 3'b111);
  assign grp_nz   = (bus.i_desc_groups != '0);
  assign desc_acc = bus.i_desc_valid & ~run;

  // Beats per group minus one: modes 0..2 take one beat, others mode-1.
  always_comb begin
    beats_m1 = 4'd0;
    if (mode_q > 4'd2) beats_m1 = mode_q - 4'd2;
  end

  assign beat_last = (beat_cnt_q == beats_m1);
  assign out_block = bus.i_dp_valid_sum & ~bus.i_out_ready;
  assign starve    = run & (beat_cnt_q != 4'd0) & ~bus.i_chunk_valid;
  assign dp_en     = ~out_block & ~starve;
  assign issue     = run & bus.i_chunk_valid & dp_en;
  assign desc_end  = issue & beat_last & (grp_left_q == GRP_W'(1));
  assign out_xfer  = bus.o_out_valid & bus.i_out_ready;
  assign flat      = bus.i_chunk_data;

  // Next state and handshake outputs.
  always_comb begin
    state_d           = state_q;
    bus.o_desc_ready  = 1'b0;
    bus.o_chunk_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.o_desc_ready = 1'b1;
        if (desc_acc && !bad_mode && grp_nz) state_d = RUN;
      end
      RUN: begin
        bus.o_chunk_ready = ~out_block;
        if (desc_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Descriptor latch and group/beat counting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q     <= '0;
      grp_left_q <= '0;
      beat_cnt_q <= '0;
    end else if (desc_acc && !bad_mode && grp_nz) begin
      mode_q     <= bus.i_desc_mode;
      grp_left_q <= bus.i_desc_groups;
      beat_cnt_q <= '0;
    end else if (issue) begin
      if (beat_last) begin
        beat_cnt_q <= '0;
        grp_left_q <= grp_left_q - GRP_W'(1);
      end else begin
        beat_cnt_q <= beat_cnt_q + 4'd1;
      end
    end
  end

  // Beats in the datapath not yet handed downstream.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inflight_q <= '0;
    end else if (issue && !out_xfer) begin
      inflight_q <= inflight_q + IFW'(1);
    end else if (!issue && out_xfer) begin
      inflight_q <= inflight_q - IFW'(1);
    end
  end

  // Tags track the datapath pipe, advancing only when it is enabled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag_q <= '0;
    end else if (dp_en) begin
      tag_q <= {tag_q[DP_LAT-2:0],
                issue ? {beat_last, desc_end} : 2'b00};
    end
  end

  // One-cycle pulse for a dropped reserved-mode descriptor.
  always_ff @(posedge i_clk) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= desc_acc & bad_mode;
  end

  assign bus.o_dp_en          = dp_en;
  assign bus.o_dp_valid_sum   = issue;
  assign bus.o_dp_length_mode = mode_q;
  assign bus.o_dp_loc_sum     = bus.i_chunk_sum;
  assign bus.o_dp_in_flat     = flat;
  assign bus.o_out_valid      = bus.i_dp_valid_sum & ~starve;
  assign bus.o_out_grp_last   = tag_q[DP_LAT-1][1];
  assign bus.o_out_desc_last  = tag_q[DP_LAT-1][0];
  assign bus.o_err            = err_q;
  assign bus.o_idle           = ~run & (inflight_q == '0);

endmodule

// File: tb/tb_acc_fwd_scheduler.sv
// tb_acc_fwd_scheduler: directed vectors against a behavioural
// DP_LAT-deep datapath model with hand-derived expectations.
module tb_acc_fwd_scheduler;

  localparam int DATA_W = 1024;
  localparam int DP_LAT = 12;
  localparam int GRP_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc_n = 0;
  int   err_cnt = 0;

  logic [31:0] dp_q[$];
  int          dp_t[$];
  logic [33:0] out_q[$];
  int          out_t[$];

  acc_fwd_scheduler_if #(.DATA_W(DATA_W), .GRP_W(GRP_W)) sif ();

  acc_fwd_scheduler #(
    .DATA_W(DATA_W), .DP_LAT(DP_LAT), .GRP_W(GRP_W)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (sif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic [DP_LAT-1:0] pv;
  logic [31:0]       ps [DP_LAT];

  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else if (sif.o_dp_en) begin
      pv <= {pv[DP_LAT-2:0], sif.o_dp_valid_sum};
      ps[0] <= sif.o_dp_loc_sum;
      for (int i = 1; i < DP_LAT; i++) ps[i] <= ps[i-1];
    end
  end

  assign sif.i_dp_valid_sum = pv[DP_LAT-1];

  always @(negedge clk) begin
    if (!rst) begin
      if (sif.o_dp_valid_sum) begin
        dp_q.push_back(sif.o_dp_loc_sum);
        dp_t.push_back(cyc_n);
      end
      if (sif.o_out_valid && sif.i_out_ready) begin
        out_q.push_back({ps[DP_LAT-1], sif.o_out_grp_last,
                         sif.o_out_desc_last});
        out_t.push_back(cyc_n);
      end
      if (sif.o_err) err_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rest(input string tag);
    @(negedge clk);
    chk({tag, "_desc_rdy"}, 64'(sif.o_desc_ready), 64'd1);
    chk({tag, "_dp_en"}, 64'(sif.o_dp_en), 64'd1);
    chk({tag, "_dp_vld"}, 64'(sif.o_dp_valid_sum), 64'd0);
    chk({tag, "_out_vld"}, 64'(sif.o_out_valid), 64'd0);
    chk({tag, "_idle"}, 64'(sif.o_idle), 64'd1);
    chk({tag, "_err"}, 64'(sif.o_err), 64'd0);
    tick();
  endtask

  task automatic send_desc(input int mode, input int groups);
    bit ok = 0;
    sif.i_desc_mode   = 4'(mode);
    sif.i_desc_groups = GRP_W'(groups);
    sif.i_desc_valid  = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = sif.o_desc_ready;
      tick();
    end
    sif.i_desc_valid = 1'b0;
    if (!ok) chk("desc_timeout", 64'd0, 64'd1);
  endtask

  task automatic stream(input int n, input int base, input int gap_at,
                        input int gap_len, input int hold_len);
    int k = 0;
    int gap = 0;
    int hold = 0;
    int cyc = 0;
    bit held = 0;
    bit cv;
    while (k < n && cyc < 500) begin
      cv = !(k == gap_at && gap < gap_len);
      sif.i_chunk_valid = cv;
      sif.i_chunk_sum   = 32'(base + k);
      sif.i_chunk_data  = {(DATA_W/32){32'(base + k)}};
      sif.i_out_ready   = !(hold > 0);
      @(negedge clk);
      if (cyc == 0) begin
        chk("run_desc_rdy", 64'(sif.o_desc_ready), 64'd0);
        chk("flat_pass", sif.o_dp_in_flat[63:0],
            {2{32'(base)}});
      end
      if (!cv) begin
        gap++;
        chk("gap_dp_en", 64'(sif.o_dp_en), 64'd0);
        chk("gap_dp_vld", 64'(sif.o_dp_valid_sum), 64'd0);
      end
      if (hold > 0) begin
        chk("hold_dp_en", 64'(sif.o_dp_en), 64'd0);
        chk("hold_crdy", 64'(sif.o_chunk_ready), 64'd0);
        chk("hold_oval", 64'(sif.o_out_valid), 64'd1);
        hold--;
      end else if (hold_len > 0 && !held && sif.o_out_valid) begin
        held = 1;
        hold = hold_len;
      end
      if (cv && sif.o_chunk_ready) k++;
      tick();
      cyc++;
    end
    if (k < n) chk("stream_timeout", 64'(k), 64'(n));
    sif.i_chunk_valid = 1'b0;
    sif.i_out_ready   = 1'b1;
  endtask

  task automatic drain();
    bit idle = 0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clk);
      idle = sif.o_idle;
      tick();
    end
    chk("drain_idle", 64'(idle), 64'd1);
  endtask

  task automatic verify(input int n, input int b, input int base,
                        input int d0, input int o0,
                        input int span, input int lat);
    logic        gl;
    logic        dl;
    logic [33:0] e;
    chk("dp_count", 64'(dp_q.size() - d0), 64'(n));
    chk("out_count", 64'(out_q.size() - o0), 64'(n));
    for (int i = 0; i < n; i++) begin
      gl = ((i % b) == b - 1);
      dl = (i == n - 1);
      e  = {32'(base + i), gl, dl};
      if (d0 + i < dp_q.size())
        chk("dp_sum", 64'(dp_q[d0+i]), 64'(base + i));
      if (o0 + i < out_q.size())
        chk("out_beat", 64'(out_q[o0+i]), 64'(e));
    end
    if (span >= 0 && dp_q.size() - d0 == n)
      chk("dp_span", 64'(dp_t[d0+n-1] - dp_t[d0]), 64'(span));
    if (lat >= 0 && out_q.size() > o0 && dp_q.size() > d0)
      chk("out_lat", 64'(out_t[o0] - dp_t[d0]), 64'(lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int o0;
    int e0;
    sif.i_desc_valid  = 1'b0;
    sif.i_desc_mode   = '0;
    sif.i_desc_groups = '0;
    sif.i_chunk_valid = 1'b0;
    sif.i_chunk_sum   = '0;
    sif.i_chunk_data  = '0;
    sif.i_out_ready   = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk_rest("rst");

    d0 = dp_q.size(); o0 = out_q.size();
    send_desc(3, 2);
    chk("mode_out", 64'(sif.o_dp_length_mode), 64'd3);
    stream(4, 100, -1, 0, 0);
    drain();
    verify(4, 2, 100, d0, o0, 3, DP_LAT);

    d0 = dp_q.size(); o0 = out_q.size();
    send_desc(13, 1);
    stream(12, 200, 5, 3, 0);
    drain();
    verify(12, 12, 200, d0, o0, 14, -1);

    d0 = dp_q.size(); o0 = out_q.size();
    send_desc(1, 3);
    stream(3, 300, -1, 0, 0);
    chk("busy_idle", 64'(sif.o_idle), 64'd0);
    drain();
    verify(3, 1, 300, d0, o0, 2, DP_LAT);

    d0 = dp_q.size(); o0 = out_q.size();
    send_desc(5, 5);
    stream(20, 400, -1, 0, 4);
    drain();
    verify(20, 4, 400, d0, o0, 23, DP_LAT);

    d0 = dp_q.size(); e0 = err_cnt;
    send_desc(15, 4);
    repeat (4) tick();
    chk("err_pulse", 64'(err_cnt - e0), 64'd1);
    chk("err_no_dp", 64'(dp_q.size() - d0), 64'd0);
    chk_rest("err_after");

    d0 = dp_q.size(); e0 = err_cnt;
    send_desc(4, 0);
    repeat (4) tick();
    chk("g0_no_err", 64'(err_cnt - e0), 64'd0);
    chk("g0_no_dp", 64'(dp_q.size() - d0), 64'd0);
    chk_rest("g0_after");

    send_desc(8, 1);
    stream(3, 500, -1, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_rest("mid_rst");

    d0 = dp_q.size(); o0 = out_q.size();
    send_desc(3, 1);
    stream(2, 600, -1, 0, 0);
    drain();
    verify(2, 2, 600, d0, o0, 1, DP_LAT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
